ldl_fifo_rs_v1: RTL and testbench
=================================

# ldl_fifo_rs_v1

Read-side controller for the LDL synchronous FIFO; the counterpart of the write-side block. It owns the read pointer, drives the dual-port RAM read port and reports empty and level to the consumer. It takes the write pointer from the write side and returns its own read pointer to it. Parameter `AHEAD` selects between a standard read and a show-ahead (first-word-fall-through) read with a prefetch stage.

## Interface
- `AW`, 8: RAM address width; FIFO depth is 2^AW.
- `DW`, 8: data width.
- `AHEAD`, 1: 1 = show-ahead (head word presented before `re`); 0 = standard read (data one cycle after `re`).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `re`  in  1  read request / pop.
- `empty`  out  1  no word available to the consumer.
- `ra`  out  AW  RAM read address, `r_pt[AW-1:0]`.
- `mr`  out  1  RAM read enable.
- `md`  in  DW  RAM read data; valid the cycle after `mr`, held stable until the next `mr`.
- `w_pt`  in  AW+1  write pointer from the write side.
- `r_pt`  out  AW+1  read pointer to the write side.
- `dout`  out  DW  read data to the consumer; equals `md`.
- `dv`  out  1  `dout` holds a valid word this cycle.
- `rcnt`  out  AW+1  words held: RAM words plus any prefetched word.
- `uflow`  out  1  sticky underflow flag (see Configuration).

## Operation
- RAM is non-empty when `w_pt != r_pt`. Every `mr` advances `r_pt` by 1 in the same cycle. The extra MSB gives modulo-2^(AW+1) wrap.
- `AHEAD=0`:
  - pop `fr = re & ~empty`; `mr = fr`; `empty = (w_pt == r_pt)`.
  - `dv` is registered `fr`, so it is high the cycle after the pop.
  - `rcnt = w_pt - r_pt`.
- `AHEAD=1`: a 1-bit FSM with states SHOW_IDLE (nothing on `md`) and SHOW_VALID (head word on `md`).
  - SHOW_IDLE, RAM non-empty: `mr=1`, go to SHOW_VALID.
  - SHOW_IDLE, RAM empty: stay.
  - SHOW_VALID with `re`, RAM non-empty: `mr=1`, stay in SHOW_VALID. Throughput is 1 word/cycle.
  - SHOW_VALID with `re`, RAM empty: `mr=0`, go to SHOW_IDLE.
  - SHOW_VALID without `re`: `mr=0`, stay.
  - `empty = (state==SHOW_IDLE)`; `dv = ~empty`.
  - `rcnt = (w_pt - r_pt) + (state==SHOW_VALID)`. This never exceeds 2^AW+1, so it fits in AW+1 bits.
  - The RAM slot of the prefetched word is released as soon as `mr` fires. The write side may overwrite it, and `dout` is unaffected.
- `re` while `empty` is ignored: no pointer or state change.
- Arithmetic is unsigned, with subtraction modulo 2^(AW+1).
- Reset:
  - `r_pt=0`, state SHOW_IDLE, `dv=0`, `uflow=0`.
  - `mr=0` and `empty=1` while `rst` is high.
  - `rcnt` follows `w_pt - 0`.
  - Reset mid-operation discards the prefetched word. The write side is reset in the same cycle.

## Timing
- `AHEAD=0`:
  - first write in cycle N updates `w_pt` in N+1;
  - `empty` falls in N+1;
  - `re` at N+1 gives `mr` at N+1, with `dout`/`dv` at N+2.
- `AHEAD=1`:
  - first write in cycle N; `mr` at N+1; `empty` falls and `dout` is valid at N+2.
  - Pop at cycle T presents the next word at T+1, with `empty` staying low if the RAM had data at T.
- A simultaneous write and pop on an empty RAM with a valid head: `mr` is not issued at T, so SHOW_IDLE is entered at T+1 and the refill comes at T+2.
- `r_pt` is visible to the write side the cycle after `mr`, so `full` deasserts at T+1.

## Configuration
- `LDL_FIFO_RS_UFLOW_EN` defined: `uflow` sets on any cycle with `re & empty` (not during `rst`) and stays set until `rst`.
- Not defined: `uflow` is tied to 0 and no flop is inferred.

## Structure
- Package `ldl_fifo_pkg` holds:
  - the FSM state typedef (SHOW_IDLE, SHOW_VALID);
  - a pointer-distance function `(a-b)` over AW+1 bits;
  - an empty-compare helper, shared with the write side.
- One sub-module, `ldl_fifo_ahead_stage`: holds the show-ahead FSM and its `mr`/`empty`/`dv` logic. It is instantiated only under `AHEAD=1`, via a generate; `AHEAD=0` uses inline logic.

## Test plan
Benches use AW=2 (depth 4) and DW=8, with the write side and a 1-cycle registered RAM model attached.
- AHEAD=1, single word: write 0x11 at cycle 0 -> `mr` at 1; `empty` 0, `dout`=0x11 and `rcnt`=1 at 2; pop at 3 -> `empty`=1 at 4, `r_pt`=1.
- AHEAD=1, streaming: write 0x01..0x04, then pop every cycle -> `dout` is 0x01,0x02,0x03,0x04 on consecutive cycles; `empty` rises after the last; `rcnt` reaches 0.
- Full plus prefetch: write 5 words with no pops (`full` after 4, 5th accepted once prefetch frees a slot) -> `rcnt`=5, then drain in order.
- AHEAD=0 wrap: 10 single write/pop pairs -> `r_pt` wraps 7→0, data matches, `dv` one cycle after each `re`.
- Underflow: `re` while empty with the macro defined -> `uflow`=1 next cycle and held; `r_pt` unchanged; `rst` clears it. Without the macro, `uflow` stays 0.
- Reset mid-stream: `rst` while in SHOW_VALID with 2 words in RAM -> next cycle `empty`=1, `dv`=0, `r_pt`=0, `mr`=0.

Source files
------------

// File: rtl/ldl_fifo_pkg.sv
// Shared types and pointer helpers for the LDL synchronous FIFO.
// Used by both the read-side and write-side controllers.
package ldl_fifo_pkg;

    // Widest pointer the helpers accept; callers zero-extend and truncate.
    localparam int PTR_MAX = 32;

    typedef enum logic {
        SHOW_IDLE  = 1'b0,
        SHOW_VALID = 1'b1
    } show_state_e;

    // Pointer distance a-b; the low AW+1 bits give the modulo result.
    function automatic logic [PTR_MAX-1:0] ptr_dist(
        input logic [PTR_MAX-1:0] a,
        input logic [PTR_MAX-1:0] b
    );
        return a - b;
    endfunction

    // RAM is empty when both pointers, extra wrap bit included, agree.
    function automatic logic ptr_empty(
        input logic [PTR_MAX-1:0] a,
        input logic [PTR_MAX-1:0] b
    );
        return a == b;
    endfunction

endpackage

// File: rtl/ldl_fifo_ahead_stage.sv
// Show-ahead prefetch stage: keeps the head word on md and issues mr.
// Ports: clk, rst, re (pop), ram_ne (RAM holds words) -> mr, empty, dv, valid.
module ldl_fifo_ahead_stage
    import ldl_fifo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic re,
    input  logic ram_ne,
    output logic mr,
    output logic empty,
    output logic dv,
    output logic valid
);

    show_state_e state;
    show_state_e state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHOW_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mr        = 1'b0;
        if (!rst) begin
            unique case (state)
                SHOW_IDLE: begin
                    if (ram_ne) begin
                        mr        = 1'b1;
                        state_nxt = SHOW_VALID;
                    end
                end
                SHOW_VALID: begin
                    // A pop either refills the head or drops to idle.
                    if (re) begin
                        if (ram_ne) begin
                            mr = 1'b1;
                        end else begin
                            state_nxt = SHOW_IDLE;
                        end
                    end
                end
                default: state_nxt = SHOW_IDLE;
            endcase
        end
    end

    assign valid = (state == SHOW_VALID);
    assign empty = rst | ~valid;
    assign dv    = ~empty;

endmodule

// File: rtl/ldl_fifo_rs_v1.sv
// LDL FIFO read-side controller: read pointer, RAM read port, empty/level.
// Ports: clk, rst, re; RAM ra/mr/md; w_pt in, r_pt out; dout, dv, rcnt, uflow.
// AHEAD=1 selects show-ahead via ldl_fifo_ahead_stage; AHEAD=0 standard read.
// Define LDL_FIFO_RS_UFLOW_EN for a sticky underflow flag; else uflow is 0.
module ldl_fifo_rs_v1
    import ldl_fifo_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int AHEAD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    output logic          empty,
    output logic [AW-1:0] ra,
    output logic          mr,
    input  logic [DW-1:0] md,
    input  logic [AW:0]   w_pt,
    output logic [AW:0]   r_pt,
    output logic [DW-1:0] dout,
    output logic          dv,
    output logic [AW:0]   rcnt,
    output logic          uflow
);

    logic [AW:0] r_pt_q;
    logic [AW:0] ram_cnt;
    logic        ram_ne;

    assign ram_ne  = ~ptr_empty(PTR_MAX'(w_pt), PTR_MAX'(r_pt_q));
    assign ram_cnt = (AW+1)'(ptr_dist(PTR_MAX'(w_pt), PTR_MAX'(r_pt_q)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pt_q <= '0;
        end else if (mr) begin
            r_pt_q <= r_pt_q + (AW+1)'(1);
        end
    end

    assign r_pt = r_pt_q;
    assign ra   = r_pt_q[AW-1:0];
    assign dout = md;

    if (AHEAD != 0) begin : g_ahead
        logic valid;

        ldl_fifo_ahead_stage u_stage (
            .clk    (clk),
            .rst    (rst),
            .re     (re),
            .ram_ne (ram_ne),
            .mr     (mr),
            .empty  (empty),
            .dv     (dv),
            .valid  (valid)
        );

        // The prefetched word still counts as held.
        assign rcnt = rst ? w_pt : ram_cnt + (AW+1)'(valid);
    end else begin : g_std
        logic fr;
        logic dv_q;

        assign empty = rst | ~ram_ne;
        assign fr    = re & ~empty;
        assign mr    = fr;

        always_ff @(posedge clk) begin
            if (rst) begin
                dv_q <= 1'b0;
            end else begin
                dv_q <= fr;
            end
        end

        assign dv   = dv_q;
        assign rcnt = rst ? w_pt : ram_cnt;
    end

`ifdef LDL_FIFO_RS_UFLOW_EN
    logic uflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            uflow_q <= 1'b0;
        end else if (re & empty) begin
            uflow_q <= 1'b1;
        end
    end

    assign uflow = uflow_q;
`else
    assign uflow = 1'b0;
`endif

endmodule

// File: tb/tb_ldl_fifo_rs_v1.sv
// Bench for ldl_fifo_rs_v1: AHEAD=0 and AHEAD=1 instances side by side,
// each with a write-side pointer, 4-entry RAM and a word-queue model.
module tb_ldl_fifo_rs_v1;

`ifdef LDL_FIFO_RS_UFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we[2];
    logic [7:0] wd[2];
    logic       re[2];

    logic       empty[2];
    logic [1:0] ra[2];
    logic       mr[2];
    logic [7:0] md[2];
    logic [2:0] w_pt[2];
    logic [2:0] r_pt[2];
    logic [7:0] dout[2];
    logic       dv[2];
    logic [2:0] rcnt[2];
    logic       uflow[2];
    logic       full[2];
    logic [7:0] mem[2][4];

    int checks = 0;
    int errors = 0;

    // Reference model: words accepted and popped, per instance.
    logic [7:0] mq[2][64];
    int         wr_n[2];
    int         pop_n[2];
    int         lastw[2];
    logic       uf[2];
    logic       pend_v;
    logic [7:0] pend_d;

    always #5 clk = ~clk;

    ldl_fifo_rs_v1 #(.AW(2), .DW(8), .AHEAD(0)) u_std (
        .clk(clk), .rst(rst), .re(re[0]), .empty(empty[0]),
        .ra(ra[0]), .mr(mr[0]), .md(md[0]), .w_pt(w_pt[0]),
        .r_pt(r_pt[0]), .dout(dout[0]), .dv(dv[0]),
        .rcnt(rcnt[0]), .uflow(uflow[0])
    );

    ldl_fifo_rs_v1 #(.AW(2), .DW(8), .AHEAD(1)) u_ahd (
        .clk(clk), .rst(rst), .re(re[1]), .empty(empty[1]),
        .ra(ra[1]), .mr(mr[1]), .md(md[1]), .w_pt(w_pt[1]),
        .r_pt(r_pt[1]), .dout(dout[1]), .dv(dv[1]),
        .rcnt(rcnt[1]), .uflow(uflow[1])
    );

    // Write side and registered RAM for both instances.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            full[g] = (w_pt[g] - r_pt[g]) == 3'd4;
        end
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                w_pt[g] <= '0;
            end else if (we[g] && !full[g]) begin
                mem[g][w_pt[g][1:0]] <= wd[g];
                w_pt[g] <= w_pt[g] + 3'd1;
            end
            if (mr[g]) md[g] <= mem[g][ra[g]];
        end
    end

    task automatic chk(input string tag, input int g,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, g, obs, exp);
        end
    endtask

    task automatic cycle();
        logic       aw[2];
        logic       ap[2];
        logic       hit[2];
        logic [7:0] pd;
        int         cnt;
        int         elig;
        for (int g = 0; g < 2; g++) begin
            aw[g]  = !rst && we[g] && !full[g];
            ap[g]  = !rst && re[g] && !empty[g];
            hit[g] = !rst && re[g] && empty[g];
        end
        pd = mq[0][pop_n[0] & 63];
        @(posedge clk);
        #1;
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                wr_n[g] = 0; pop_n[g] = 0; lastw[g] = 0; uf[g] = 1'b0;
            end
            pend_v = 1'b0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                lastw[g] = aw[g] ? 1 : 0;
                if (aw[g]) begin
                    mq[g][wr_n[g] & 63] = wd[g];
                    wr_n[g]++;
                end
                if (ap[g]) pop_n[g]++;
                if (hit[g] && UF_EN) uf[g] = 1'b1;
            end
            pend_v = ap[0];
            pend_d = pd;
        end
        for (int g = 0; g < 2; g++) begin
            cnt = wr_n[g] - pop_n[g];
            chk("rcnt", g, 32'(rcnt[g]), 32'(cnt & 7));
            chk("uflow", g, 32'(uflow[g]), 32'(uf[g]));
        end
        cnt = wr_n[0] - pop_n[0];
        chk("empty", 0, 32'(empty[0]), 32'(cnt == 0));
        chk("dv", 0, 32'(dv[0]), 32'(pend_v));
        chk("r_pt", 0, 32'(r_pt[0]), 32'(pop_n[0] & 7));
        if (pend_v) chk("dout", 0, 32'(dout[0]), 32'(pend_d));
        // A word reaches the show-ahead head two cycles after its write.
        elig = wr_n[1] - lastw[1] - pop_n[1];
        chk("empty", 1, 32'(empty[1]), 32'(elig == 0));
        chk("dv", 1, 32'(dv[1]), 32'(elig != 0));
        if (elig != 0) chk("head", 1, 32'(dout[1]), 32'(mq[1][pop_n[1] & 63]));
    endtask

    task automatic idle_in();
        we = '{1'b0, 1'b0};
        re = '{1'b0, 1'b0};
        wd = '{8'h00, 8'h00};
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            wr_n[g] = 0; pop_n[g] = 0; lastw[g] = 0; uf[g] = 1'b0;
        end
        pend_v = 1'b0;
        pend_d = 8'h00;
        idle_in();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Single word through the show-ahead path.
        we = '{1'b1, 1'b1};
        wd = '{8'h11, 8'h11};
        cycle();
        idle_in();
        #1;
        chk("mr_prefetch", 1, 32'(mr[1]), 32'd1);
        cycle();
        chk("single_empty", 1, 32'(empty[1]), 32'd0);
        chk("single_dout", 1, 32'(dout[1]), 32'h11);
        chk("single_rcnt", 1, 32'(rcnt[1]), 32'd1);
        cycle();
        re = '{1'b1, 1'b1};
        cycle();
        idle_in();
        chk("single_pop_empty", 1, 32'(empty[1]), 32'd1);
        chk("single_r_pt", 1, 32'(r_pt[1]), 32'd1);
        chk("std_dv", 0, 32'(dv[0]), 32'd1);
        chk("std_dout", 0, 32'(dout[0]), 32'h11);

        // Streaming four words, one pop per cycle.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            we = '{1'b1, 1'b1};
            wd = '{8'(k + 1), 8'(k + 1)};
            cycle();
        end
        idle_in();
        for (int k = 0; k < 4; k++) begin
            re = '{1'b1, 1'b1};
            chk("stream", 1, 32'(dout[1]), 32'(k + 1));
            cycle();
        end
        idle_in();
        chk("stream_empty", 1, 32'(empty[1]), 32'd1);
        chk("stream_rcnt", 1, 32'(rcnt[1]), 32'd0);

        // Fill: four RAM words plus the prefetched head.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            we = '{1'b1, 1'b1};
            wd = '{8'(8'hA0 + k), 8'(8'hA0 + k)};
            cycle();
        end
        idle_in();
        chk("full_rcnt", 1, 32'(rcnt[1]), 32'd5);
        chk("full_rcnt", 0, 32'(rcnt[0]), 32'd4);
        for (int k = 0; k < 6; k++) begin
            re = '{!empty[0], !empty[1]};
            cycle();
        end
        idle_in();
        chk("drain_rcnt", 1, 32'(rcnt[1]), 32'd0);

        // Standard read: pointer wrap over ten write/pop pairs.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            we[0] = 1'b1;
            wd[0] = 8'(8'h30 + k);
            cycle();
            we[0] = 1'b0;
            re[0] = 1'b1;
            cycle();
            re[0] = 1'b0;
            chk("wrap_dv", 0, 32'(dv[0]), 32'd1);
            chk("wrap_dout", 0, 32'(dout[0]), 32'(8'h30 + k));
        end
        chk("wrap_r_pt", 0, 32'(r_pt[0]), 32'd2);

        // Underflow: pop while empty.
        do_reset();
        re = '{1'b1, 1'b1};
        cycle();
        idle_in();
        chk("uflow_set", 1, 32'(uflow[1]), 32'(UF_EN));
        chk("uflow_r_pt", 1, 32'(r_pt[1]), 32'd0);
        cycle();
        chk("uflow_hold", 0, 32'(uflow[0]), 32'(UF_EN));
        do_reset();
        chk("uflow_clr", 1, 32'(uflow[1]), 32'd0);

        // Reset with a valid head and two words in RAM.
        for (int k = 0; k < 3; k++) begin
            we[1] = 1'b1;
            wd[1] = 8'(8'h50 + k);
            cycle();
        end
        idle_in();
        chk("mid_rcnt", 1, 32'(rcnt[1]), 32'd3);
        rst = 1'b1;
        #1;
        chk("rst_mr", 1, 32'(mr[1]), 32'd0);
        chk("rst_empty", 1, 32'(empty[1]), 32'd1);
        cycle();
        rst = 1'b0;
        #1;
        chk("mid_empty", 1, 32'(empty[1]), 32'd1);
        chk("mid_dv", 1, 32'(dv[1]), 32'd0);
        chk("mid_r_pt", 1, 32'(r_pt[1]), 32'd0);
        chk("mid_mr", 1, 32'(mr[1]), 32'd0);

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int g = 0; g < 2; g++) begin
                we[g] = 1'($urandom_range(0, 1));
                wd[g] = 8'($urandom);
                re[g] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        rst = 1'b0;
        idle_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
